// File: rtl/lsu_mem_bridge.sv
// Single-outstanding bridge from an LSU request port to a simple 8-byte memory model.
// Optional misalignment trapping: define LSU_BRIDGE_MISALIGN_CHECK_EN.
`timescale 1ns/1ps
module lsu_mem_bridge #(
    parameter logic [63:0] PMEM_BASE = 64'h0000_0000_8000_0000,
    parameter logic [63:0] PMEM_SIZE = 64'h0000_0000_0800_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_rd_en,
    output logic [63:0] mem_rd_addr,
    input  logic [63:0] mem_rd_data,
    output logic        mem_we_en,
    output logic [63:0] mem_we_addr,
    output logic [63:0] mem_we_data,
    output logic [7:0]  mem_we_mask,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic        wen_q, wen_d;
    logic        rd_en_q, rd_en_d;
    logic        we_en_q, we_en_d;
    logic        resp_valid_q, resp_valid_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        accept;
    logic [64:0] req_last;
    logic [64:0] pmem_last;
    logic        range_err;
    logic        misalign_err;
    logic        req_err;
    logic [63:0] load_ext;
    logic [7:0]  size_mask;

    // Handshakes are valid/ready: a transfer happens on a rising edge where both are 1;
    // the sender holds its payload stable while valid is high and ready is low.
    assign accept = req_valid && req_ready;

    // Range math is 65 bits wide so an access wrapping past 2^64 is caught.
    always_comb begin
        req_last  = {1'b0, req_addr} + (65'd1 << req_size) - 65'd1;
        pmem_last = {1'b0, PMEM_BASE} + {1'b0, PMEM_SIZE} - 65'd1;
        range_err = ({1'b0, req_addr} < {1'b0, PMEM_BASE}) || (req_last > pmem_last);
    end

`ifdef LSU_BRIDGE_MISALIGN_CHECK_EN
    always_comb begin
        case (req_size)
            2'd1:    misalign_err = req_addr[0];
            2'd2:    misalign_err = |req_addr[1:0];
            2'd3:    misalign_err = |req_addr[2:0];
            default: misalign_err = 1'b0;
        endcase
    end
`else
    assign misalign_err = 1'b0;
`endif

    assign req_err = range_err || misalign_err;

    always_comb begin
        case (size_q)
            2'd0:    load_ext = {{56{signed_q & mem_rd_data[7]}},  mem_rd_data[7:0]};
            2'd1:    load_ext = {{48{signed_q & mem_rd_data[15]}}, mem_rd_data[15:0]};
            2'd2:    load_ext = {{32{signed_q & mem_rd_data[31]}}, mem_rd_data[31:0]};
            default: load_ext = mem_rd_data;
        endcase
    end

    always_comb begin
        case (size_q)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        signed_d     = signed_q;
        wen_d        = wen_q;
        rd_en_d      = 1'b0;
        we_en_d      = 1'b0;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    size_d       = req_size;
                    signed_d     = req_signed;
                    wen_d        = req_wen;
                    resp_rdata_d = 64'd0;
                    resp_err_d   = req_err;
                    if (req_err) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = S_ACCESS;
                        rd_en_d = !req_wen;
                        we_en_d = req_wen;
                    end
                end
            end
            S_ACCESS: begin
                resp_rdata_d = wen_q ? 64'd0 : load_ext;
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                state_d      = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= 64'd0;
            wdata_q      <= 64'd0;
            size_q       <= 2'd0;
            signed_q     <= 1'b0;
            wen_q        <= 1'b0;
            rd_en_q      <= 1'b0;
            we_en_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            wen_q        <= wen_d;
            rd_en_q      <= rd_en_d;
            we_en_q      <= we_en_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Address/data are gated by the flopped enables so they read 0 outside ACCESS.
    assign req_ready   = (state_q == S_IDLE) && !reset;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = rd_en_q ? addr_q : 64'd0;
    assign mem_we_en   = we_en_q;
    assign mem_we_addr = we_en_q ? addr_q : 64'd0;
    assign mem_we_data = we_en_q ? wdata_q : 64'd0;
    assign mem_we_mask = we_en_q ? size_mask : 8'd0;
    assign dbg_state_o = state_q;

endmodule
